// File: rtl/demux_sched_pkg.sv
// demux_sched shared types and sizes.
// Optional per-destination beat statistics: DEMUX_SCHED_STATS_EN.
package demux_sched_pkg;

    localparam int REQ_N  = 4;
    localparam int DATA_W = 4;
    localparam int SEL_W  = 2;
    localparam int CNT_W  = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/demux_sched_rr_pick.sv
// Combinational 4-way round-robin pick.
// Search order: start, start+1, start+2, start+3 (mod 4).
module rr_pick
    import demux_sched_pkg::*;
(
    input  logic [REQ_N-1:0] req_i,
    input  logic [SEL_W-1:0] start_i,
    output logic [REQ_N-1:0] gnt_o,
    output logic             valid_o
);

    logic [SEL_W-1:0] idx;

    // First set request in rotated order wins
    always_comb begin
        gnt_o   = '0;
        valid_o = 1'b0;
        idx     = '0;
        for (int k = 0; k < REQ_N; k++) begin
            idx = start_i + SEL_W'(k);
            if (!valid_o && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                valid_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_sched.sv
// Round-robin burst scheduler feeding a 1-to-4 demultiplexer.
// Define DEMUX_SCHED_STATS_EN to add per-destination beat counters.
module demux_sched
    import demux_sched_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter int STALL_MAX = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [REQ_N-1:0]        req,
    input  logic [REQ_N*DATA_W-1:0] req_data,
    input  logic [REQ_N*SEL_W-1:0]  req_dest,
    input  logic [REQ_N-1:0]        dst_ready,
`ifdef DEMUX_SCHED_STATS_EN
    input  logic                    stat_clr,
    output logic [31:0]             stat_beats,
`endif
    output logic [REQ_N-1:0]        gnt,
    output logic [DATA_W-1:0]       dmx_data,
    output logic [SEL_W-1:0]        dmx_sel,
    output logic                    dmx_valid,
    output logic                    busy
);

    state_e            state_q;
    logic [REQ_N-1:0]  gnt_q;
    logic [DATA_W-1:0] dmx_data_q;
    logic [SEL_W-1:0]  dmx_sel_q;
    logic              dmx_valid_q;
    logic [SEL_W-1:0]  last_q;
    logic [CNT_W-1:0]  burst_q;
    logic [CNT_W-1:0]  stall_q;

    logic [SEL_W-1:0]  own;
    logic [SEL_W-1:0]  dest;
    logic [DATA_W-1:0] own_data;
    logic              beat;
    logic              stall;
    logic              drop;
    logic              rel;
    logic [SEL_W-1:0]  start;
    logic [REQ_N-1:0]  pick_gnt;
    logic              pick_v;

    // Owner index from the one-hot grant
    always_comb begin
        own = '0;
        unique case (1'b1)
            gnt_q[0]: own = 2'd0;
            gnt_q[1]: own = 2'd1;
            gnt_q[2]: own = 2'd2;
            gnt_q[3]: own = 2'd3;
            default:  own = 2'd0;
        endcase
    end

    assign dest     = req_dest[own*SEL_W +: SEL_W];
    assign own_data = req_data[own*DATA_W +: DATA_W];

    // Classify the current GRANT cycle and decide on release
    always_comb begin
        beat  = (state_q == GRANT) && req[own] && dst_ready[dest];
        stall = (state_q == GRANT) && req[own] && !dst_ready[dest];
        drop  = (state_q == GRANT) && !req[own];
        rel   = drop
              || (beat  && burst_q == CNT_W'(MAX_BURST - 1))
              || (stall && stall_q == CNT_W'(STALL_MAX - 1));
        start = (state_q == GRANT) ? own + 2'd1 : last_q + 2'd1;
    end

    rr_pick u_pick (
        .req_i   (req),
        .start_i (start),
        .gnt_o   (pick_gnt),
        .valid_o (pick_v)
    );

    // Scheduler FSM with registered grant and demux outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            dmx_data_q  <= '0;
            dmx_sel_q   <= '0;
            dmx_valid_q <= 1'b0;
            last_q      <= 2'd3;
            burst_q     <= '0;
            stall_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    dmx_valid_q <= 1'b0;
                    if (pick_v) begin
                        gnt_q   <= pick_gnt;
                        burst_q <= '0;
                        stall_q <= '0;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (beat) begin
                        dmx_data_q  <= own_data;
                        dmx_sel_q   <= dest;
                        dmx_valid_q <= 1'b1;
                        burst_q     <= burst_q + 1'b1;
                        stall_q     <= '0;
                    end else begin
                        dmx_valid_q <= 1'b0;
                        if (stall) stall_q <= stall_q + 1'b1;
                    end
                    if (rel) begin
                        last_q  <= own;
                        burst_q <= '0;
                        stall_q <= '0;
                        if (pick_v) begin
                            gnt_q <= pick_gnt;
                        end else begin
                            gnt_q   <= '0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign dmx_data  = dmx_data_q;
    assign dmx_sel   = dmx_sel_q;
    assign dmx_valid = dmx_valid_q;
    assign busy      = (state_q == GRANT);

`ifdef DEMUX_SCHED_STATS_EN
    logic [7:0] stat_q [REQ_N];

    // Saturating per-destination beat counters, clear beats increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < REQ_N; k++) stat_q[k] <= '0;
        end else begin
            for (int k = 0; k < REQ_N; k++) begin
                if (stat_clr) begin
                    stat_q[k] <= '0;
                end else if (beat && dest == SEL_W'(k)
                             && stat_q[k] != 8'hFF) begin
                    stat_q[k] <= stat_q[k] + 8'd1;
                end
            end
        end
    end

    assign stat_beats = {stat_q[3], stat_q[2], stat_q[1], stat_q[0]};
`endif

endmodule

// File: tb/tb_demux_sched.sv
// Directed table-driven bench for demux_sched.
// Build with DEMUX_SCHED_STATS_EN to also check the beat counters.
module tb_demux_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  req = '0;
    logic [15:0] req_data = '0;
    logic [7:0]  req_dest = '0;
    logic [3:0]  dst_ready = '0;
    logic [3:0]  gnt;
    logic [3:0]  dmx_data;
    logic [1:0]  dmx_sel;
    logic        dmx_valid;
    logic        busy;
`ifdef DEMUX_SCHED_STATS_EN
    logic        stat_clr = 1'b0;
    logic [31:0] stat_beats;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    demux_sched #(.MAX_BURST(4), .STALL_MAX(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_data  (req_data),
        .req_dest  (req_dest),
        .dst_ready (dst_ready),
`ifdef DEMUX_SCHED_STATS_EN
        .stat_clr  (stat_clr),
        .stat_beats(stat_beats),
`endif
        .gnt       (gnt),
        .dmx_data  (dmx_data),
        .dmx_sel   (dmx_sel),
        .dmx_valid (dmx_valid),
        .busy      (busy)
    );

    typedef struct {
        logic [3:0] req;
        logic [3:0] data;
        logic [3:0] gnt;
        logic       v;
        logic [3:0] dd;
        logic [1:0] sel;
        logic       busy;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // {gnt, valid, data, sel, busy}
    function automatic logic [31:0] outs();
        return {20'd0, gnt, dmx_valid, dmx_data, dmx_sel, busy};
    endfunction

    function automatic logic [31:0] pack(input logic [3:0] g,
        input logic v, input logic [3:0] d, input logic [1:0] s,
        input logic b);
        return {20'd0, g, v, d, s, b};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req       = '0;
        req_data  = '0;
        req_dest  = '0;
        dst_ready = '0;
        #2;
        rst_n = 1'b0;
        #2;
        chk("reset_outs", outs(), pack(4'd0, 1'b0, 4'd0, 2'd0, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        // req0 alone, dest C, data 5..9, then drop
        tbl[0] = '{4'b0001, 4'd5, 4'b0001, 1'b0, 4'd0, 2'd0, 1'b1};
        tbl[1] = '{4'b0001, 4'd5, 4'b0001, 1'b1, 4'd5, 2'd2, 1'b1};
        tbl[2] = '{4'b0001, 4'd6, 4'b0001, 1'b1, 4'd6, 2'd2, 1'b1};
        tbl[3] = '{4'b0001, 4'd7, 4'b0001, 1'b1, 4'd7, 2'd2, 1'b1};
        tbl[4] = '{4'b0001, 4'd8, 4'b0001, 1'b1, 4'd8, 2'd2, 1'b1};
        tbl[5] = '{4'b0001, 4'd9, 4'b0001, 1'b1, 4'd9, 2'd2, 1'b1};
        tbl[6] = '{4'b0000, 4'd9, 4'b0000, 1'b0, 4'd9, 2'd2, 1'b0};
        tbl[7] = '{4'b0000, 4'd9, 4'b0000, 1'b0, 4'd9, 2'd2, 1'b0};

        do_reset();
        req_dest  = 8'h02;
        dst_ready = 4'hF;
        for (int i = 0; i < 8; i++) begin
            req      = tbl[i].req;
            req_data = {12'd0, tbl[i].data};
            step();
            chk($sformatf("single_v%0d", i), outs(),
                pack(tbl[i].gnt, tbl[i].v, tbl[i].dd,
                     tbl[i].sel, tbl[i].busy));
        end

        // All four requesting: 0,1,2,3,0 with 4 beats each
        do_reset();
        req       = 4'b1111;
        req_data  = {4'd6, 4'd5, 4'd4, 4'd3};
        req_dest  = {2'd0, 2'd1, 2'd2, 2'd3};
        dst_ready = 4'hF;
        step();
        chk("rr_first_gnt", {28'd0, gnt, 1'b0}, {28'd0, 4'b0001, dmx_valid});
        for (int k = 2; k <= 18; k++) begin
            int op;
            int on;
            step();
            op = ((k - 2) / 4) % 4;
            on = ((k - 1) / 4) % 4;
            chk($sformatf("rr_c%0d", k), outs(),
                pack(4'(1 << on), 1'b1, 4'(op + 3), 2'(3 - op), 1'b1));
        end

        // Requester 1 stalls on dest D, released to requester 2
        do_reset();
        req       = 4'b0110;
        req_data  = {8'd0, 4'hA, 4'h1, 4'd0};
        req_dest  = {2'd0, 2'd0, 2'd3, 2'd0};
        dst_ready = 4'b0111;
        step();
        chk("stall_gnt", outs(), pack(4'b0010, 1'b0, 4'd0, 2'd0, 1'b1));
        for (int k = 2; k <= 9; k++) begin
            step();
            chk($sformatf("stall_c%0d", k), outs(),
                pack((k == 9) ? 4'b0100 : 4'b0010,
                     1'b0, 4'd0, 2'd0, 1'b1));
        end
        step();
        chk("stall_next_beat", outs(),
            pack(4'b0100, 1'b1, 4'hA, 2'd0, 1'b1));

        // Owner drops after two beats
        do_reset();
        req       = 4'b0001;
        req_data  = 16'h0003;
        req_dest  = 8'h01;
        dst_ready = 4'hF;
        step();
        step();
        chk("drop_b1", outs(), pack(4'b0001, 1'b1, 4'd3, 2'd1, 1'b1));
        req_data = 16'h0004;
        step();
        chk("drop_b2", outs(), pack(4'b0001, 1'b1, 4'd4, 2'd1, 1'b1));
        req = 4'b0000;
        step();
        chk("drop_dead", outs(), pack(4'b0000, 1'b0, 4'd4, 2'd1, 1'b0));
        step();
        chk("drop_idle", outs(), pack(4'b0000, 1'b0, 4'd4, 2'd1, 1'b0));

        // Asynchronous reset mid-burst
        do_reset();
        req       = 4'b1111;
        req_data  = {4'd6, 4'd5, 4'd4, 4'd3};
        req_dest  = {2'd0, 2'd1, 2'd2, 2'd3};
        dst_ready = 4'hF;
        step();
        step();
        step();
        chk("pre_arst", outs(), pack(4'b0001, 1'b1, 4'd3, 2'd3, 1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_immediate", outs(), pack(4'd0, 1'b0, 4'd0, 2'd0, 1'b0));
        #1;
        rst_n = 1'b1;
        step();
        chk("arst_regrant", outs(), pack(4'b0001, 1'b0, 4'd0, 2'd0, 1'b1));

`ifdef DEMUX_SCHED_STATS_EN
        do_reset();
        req       = 4'b0001;
        req_data  = 16'h0007;
        req_dest  = 8'h01;
        dst_ready = 4'hF;
        for (int i = 0; i < 300; i++) step();
        chk("stat_sat", stat_beats, 32'h0000_FF00);
        req      = 4'b0000;
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        chk("stat_clr", stat_beats, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
